// File: rtl/booth_mult_unit.sv
// booth_mult_unit
// Multi-cycle radix-2 Booth multiplier for the HI/LO unit.
// Handles signed (MULT) and unsigned (MULTU) operands. It captures the operands
// on an accepted start and runs one Booth step per clock for WIDTH+1 steps. It
// then loads the 2*WIDTH-bit product into hi/lo and pulses done for one cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request a multiply (sampled only in IDLE or DONE)
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   a, b       multiplicand / multiplier, captured at an accepted start
//   hi, lo     upper / lower half of the product, held until the next completion
//   busy       high while iterating
//   done       single-cycle completion pulse; hi/lo valid from this cycle
module booth_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    // Operands are carried one bit wider than WIDTH. With that extra bit, Booth
    // recoding covers unsigned values and the most-negative signed value
    // without any correction step.
    localparam int EW = WIDTH + 1;
    // Product register layout: {accumulator[EW], multiplier[EW], guard[1]}.
    localparam int PW = 2 * EW + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_last;

    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_prod;
    logic [EW-1:0]   r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [EW-1:0]   w_a_ext;
    logic [EW-1:0]   w_b_ext;
    logic [EW-1:0]   w_acc;
    logic [EW-1:0]   w_acc_sum;
    logic [PW-1:0]   w_shift;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // The step performed in this cycle is the (WIDTH+1)-th.
                if (r_cnt == CW'(WIDTH)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Booth datapath
    // ------------------------------------------------------------------
    assign w_a_ext = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
    assign w_b_ext = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
    assign w_acc   = r_prod[PW-1 -: EW];

    always_comb begin
        w_acc_sum = w_acc;
        case (r_prod[1:0])
            2'b10:   w_acc_sum = w_acc - r_mcand;
            2'b01:   w_acc_sum = w_acc + r_mcand;
            default: w_acc_sum = w_acc;
        endcase
    end

    // Arithmetic right shift of {new accumulator, multiplier, guard}.
    // The old guard bit falls off the end.
    assign w_shift = {w_acc_sum[EW-1], w_acc_sum, r_prod[EW:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_prod  <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_accept) begin
            r_mcand <= w_a_ext;
            r_prod  <= {{EW{1'b0}}, w_b_ext, 1'b0};
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_prod <= w_shift;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                // The product fits in 2*WIDTH bits for both modes. The top two
                // bits of {acc, multiplier} are pure sign extension.
                {r_hi, r_lo} <= w_shift[2*WIDTH:1];
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_booth_mult_unit.sv
module tb_booth_mult_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [31:0] hi32, lo32;
    logic        busy32, done32;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  hi8, lo8;
    logic        busy8, done8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    booth_mult_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
        .a(a32), .b(b32), .hi(hi32), .lo(lo32), .busy(busy32), .done(done32)
    );

    booth_mult_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
    );

    // Reference model: the mathematical product of the operands.
    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint px, py;
        logic [63:0] ux, uy;
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
            return 64'(px * py);
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return ux * uy;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int px, py;
        if (s) begin
            px = int'($signed(x));
            py = int'($signed(y));
        end else begin
            px = int'({24'd0, x});
            py = int'({24'd0, y});
        end
        return 16'(px * py);
    endfunction

    // Drives one operation and waits for done (bounded). cyc is the number of
    // cycles from the accepting edge to done.
    task automatic do_op32(input logic [31:0] x, input logic [31:0] y, input logic s,
                           output logic [63:0] prod, output int cyc, output bit ok, output bit excl);
        excl = 1'b1;
        @(negedge clk);
        a32 = x; b32 = y; sgn32 = s; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        cyc = 0;
        while (!done32 && cyc < 100) begin
            if (!busy32) excl = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (busy32 && done32) excl = 1'b0;
        ok = done32;
        prod = {hi32, lo32};
    endtask

    task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                          output logic [15:0] prod, output int cyc, output bit ok);
        @(negedge clk);
        a8 = x; b8 = y; sgn8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        ok = done8 && !busy8;
        prod = {hi8, lo8};
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({hi32, lo32} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_hilo32: got %h expected 0", {hi32, lo32});
        end
        tests_run++;
        if ({busy32, done32} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_flags32: got busy=%b done=%b expected 0 0", busy32, done32);
        end
        tests_run++;
        if ({hi8, lo8, busy8, done8} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_all8: got %h expected 0", {hi8, lo8, busy8, done8});
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy32, done32} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy32, done32);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] tb [6] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000002, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic        ts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] prod, exp;
        int cyc;
        bit ok, excl;
        for (int i = 0; i < 6; i++) begin
            do_op32(ta[i], tb[i], ts[i], prod, cyc, ok, excl);
            exp = ref32(ta[i], tb[i], ts[i]);
            $display("[TB] directed %0d: %h x %h s=%b -> %h cyc=%0d", i, ta[i], tb[i], ts[i], prod, cyc);
            tests_run++;
            if (!ok || prod !== exp) begin
                tests_failed++;
                $display("FAIL directed_prod_%0d: got %h expected %h (done=%b)", i, prod, exp, ok);
            end
            tests_run++;
            if (cyc !== 33 || !excl) begin
                tests_failed++;
                $display("FAIL directed_latency_%0d: got %0d cycles excl=%b expected 33 cycles excl=1", i, cyc, excl);
            end
        end
    endtask

    task automatic test_random32();
        logic [31:0] x, y;
        logic s;
        logic [63:0] prod, exp;
        int cyc;
        bit ok, excl;
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            y = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i == 0) x = 32'h80000000;
            if (i == 1) y = 32'h7FFFFFFF;
            do_op32(x, y, s, prod, cyc, ok, excl);
            exp = ref32(x, y, s);
            $display("[TB] random32 %0d: %h x %h s=%b -> %h", i, x, y, s, prod);
            tests_run++;
            if (!ok || !excl || prod !== exp) begin
                tests_failed++;
                $display("FAIL random32_%0d: got %h expected %h (done=%b excl=%b)", i, prod, exp, ok, excl);
            end
        end
    endtask

    task automatic test_busy_robust();
        logic [63:0] prior, result;
        int dones;
        bit hold_ok;
        prior = {hi32, lo32};
        result = '0;
        dones = 0;
        hold_ok = 1'b1;
        @(negedge clk);
        a32 = 32'd7; b32 = 32'd6; sgn32 = 1'b1; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin start32 = 1'b1; a32 = 32'h1234; b32 = 32'h10; end
            if (c == 6) start32 = 1'b0;
            if (c == 8) begin sgn32 = 1'b0; a32 = 32'hFFFF; end
            if (c == 12) sgn32 = 1'b1;
            if (busy32 && {hi32, lo32} !== prior) hold_ok = 1'b0;
            @(negedge clk);
            if (done32) begin
                dones++;
                result = {hi32, lo32};
            end
        end
        $display("[TB] busy_robust: 7 x 6 -> %h dones=%0d hold=%b", result, dones, hold_ok);
        tests_run++;
        if (result !== 64'h2A) begin
            tests_failed++;
            $display("FAIL busy_result: got %h expected %h", result, 64'h2A);
        end
        tests_run++;
        if (dones !== 1) begin
            tests_failed++;
            $display("FAIL busy_single_done: got %0d expected 1", dones);
        end
        tests_run++;
        if (!hold_ok) begin
            tests_failed++;
            $display("FAIL busy_hold: got hold=0 expected hold=1 (prior %h)", prior);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] prod, exp;
        int cyc, dones;
        bit ok, excl;
        @(negedge clk);
        a32 = 32'h12345678; b32 = 32'h9ABCDEF0; sgn32 = 1'b1; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("[TB] reset_mid: hi=%h lo=%h busy=%b done=%b", hi32, lo32, busy32, done32);
        tests_run++;
        if ({hi32, lo32} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_hilo: got %h expected 0", {hi32, lo32});
        end
        tests_run++;
        if ({busy32, done32} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid_flags: got busy=%b done=%b expected 0 0", busy32, done32);
        end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done32 || busy32) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", dones);
        end
        do_op32(32'd3, 32'hFFFFFFFB, 1'b1, prod, cyc, ok, excl);
        exp = 64'hFFFFFFFF_FFFFFFF1;
        $display("[TB] after reset: 3 x -5 -> %h", prod);
        tests_run++;
        if (!ok || prod !== exp || cyc !== 33) begin
            tests_failed++;
            $display("FAIL reset_mid_rerun: got %h cyc=%0d expected %h cyc=33", prod, cyc, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2;
        logic [63:0] p1, p2;
        int cyc, t1, t2;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = $urandom;
        @(negedge clk);
        a32 = x1; b32 = y1; sgn32 = 1'b1; start32 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done32 && cyc < 100);
        t1 = cyc;
        p1 = {hi32, lo32};
        a32 = x2; b32 = y2; sgn32 = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done32 && cyc < 200);
        t2 = cyc;
        p2 = {hi32, lo32};
        start32 = 1'b0;
        $display("[TB] back_to_back: %h then %h, done gap %0d", p1, p2, t2 - t1);
        tests_run++;
        if (p1 !== ref32(x1, y1, 1'b1)) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h expected %h", p1, ref32(x1, y1, 1'b1));
        end
        tests_run++;
        if (p2 !== ref32(x2, y2, 1'b0)) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h expected %h", p2, ref32(x2, y2, 1'b0));
        end
        tests_run++;
        if (t2 - t1 !== 34) begin
            tests_failed++;
            $display("FAIL b2b_gap: got %0d expected 34", t2 - t1);
        end
        @(negedge clk);
    endtask

    task automatic test_width8();
        logic [7:0] x, y;
        logic s;
        logic [15:0] prod, exp;
        int cyc;
        bit ok;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            if (i == 0) begin x = 8'h80; y = 8'h80; s = 1'b1; end
            if (i == 1) begin x = 8'hFF; y = 8'hFF; s = 1'b0; end
            do_op8(x, y, s, prod, cyc, ok);
            exp = ref8(x, y, s);
            $display("[TB] width8 %0d: %h x %h s=%b -> %h cyc=%0d", i, x, y, s, prod, cyc);
            tests_run++;
            if (!ok || prod !== exp || cyc !== 9) begin
                tests_failed++;
                $display("FAIL width8_%0d: got %h cyc=%0d expected %h cyc=9", i, prod, cyc, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random32();
        test_busy_robust();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/booth_mult_unit.md
# booth_mult_unit

Parametrised multi-cycle radix-2 Booth multiplier for the datapath's HI/LO unit, serving both MULT (signed) and MULTU (unsigned). It captures operands on a start handshake, iterates one Booth step per cycle, then loads a 2×WIDTH product into `hi`/`lo`. It replaces the fixed 32-bit signed-only multiplier. It adds unsigned mode, exact handling of the most-negative operand, a busy/done handshake, and stable result holding.

## Interface
- `WIDTH`, default 32: operand width; `hi`/`lo` are each `WIDTH` bits; minimum 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only in IDLE or DONE.
- `is_signed`  in  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); captured with operands.
- `a`  in  `WIDTH`  multiplicand; captured at accepted start.
- `b`  in  `WIDTH`  multiplier; captured at accepted start.
- `hi`  out  `WIDTH`  upper half of product; held until next completion.
- `lo`  out  `WIDTH`  lower half of product; held until next completion.
- `busy`  out  1  high while an operation is iterating (state RUN).
- `done`  out  1  single-cycle pulse; `hi`/`lo` valid from this cycle.

## Operation
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0. State is IDLE, the iteration counter is 0, and the internal product and operand registers are 0.
- **Operand extension:** internally, operands are extended to WIDTH+1 bits. Signed mode sign-extends; unsigned mode zero-extends. Booth recoding therefore covers both modes and the most-negative value (e.g. 0x8000_0000) without special-case fix-up.
- **Internal product register:** 2×(WIDTH+1)+1 bits, holding {accumulator, multiplier, Booth guard bit}. The guard bit starts at 0.
- **Booth iteration:** each iteration examines the pair {multiplier LSB, guard}.
  - 10: accumulator −= extended `a`.
  - 01: accumulator += extended `a`.
  - 00 or 11: no add.
  - Then arithmetic-shift the whole register right by 1.
- **Iteration count:** exactly WIDTH+1 iterations. The final product is the low 2×WIDTH bits of {accumulator, multiplier}: `hi` = upper WIDTH bits, `lo` = lower WIDTH bits.
- **States:**
  - IDLE: if `start`=1, latch `a`, `b`, `is_signed`, clear the accumulator and counter, and go to RUN.
  - RUN: perform one iteration per cycle and increment the counter. On the iteration where the counter reaches WIDTH+1, load `hi`/`lo` and go to DONE.
  - DONE: `done`=1 for exactly this cycle. If `start`=1, accept a new operation exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- **`start` while in RUN:** ignored. It is neither queued nor able to disturb the operands.
- **Operand changes:** changes on `a`/`b`/`is_signed` after acceptance have no effect.
- **`hi`/`lo` update:** they change only on the edge entering DONE. At all other times they hold the previous result, including during the next RUN.
- **Counter width:** $clog2(WIDTH+2) bits.

## Timing
- **Acceptance (edge E0):** `start`=1 is sampled in IDLE or DONE at edge E0. `busy` is 1 from after E0.
- **Iterations:** edges E1..E(WIDTH+1) each perform one iteration.
- **Completion:** at E(WIDTH+1), `hi`/`lo` are loaded, `busy`→0 and `done`→1.
- **Return to IDLE:** at E(WIDTH+2), `done`→0, or a new RUN begins if `start`=1.
- **Latency:** start-to-done is WIDTH+1 cycles; WIDTH=32 gives 33.
- **Throughput:** one result per WIDTH+2 cycles, back-to-back via DONE.
- **`busy` and `done`:** never both high in the same cycle.
- **Reset at any time, including mid-RUN:**
  - Outputs go to their reset values immediately (asynchronously).
  - The in-flight operation is discarded, with no `done` pulse.
  - After `reset` deasserts, the first start proceeds normally.
- **`start` held high continuously:** one operation is accepted per DONE/IDLE visit. No operation is accepted in RUN.

## Test plan
- **Signed −1×−1 and signed most-negative squared (WIDTH=32):**
  - `is_signed`=1, a=b=0xFFFFFFFF → `hi`=0x00000000, `lo`=0x00000001.
  - a=b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
  - `done` pulses exactly 33 cycles after the accepting edge.
- **Mode contrast:** a=0xFFFFFFFF, b=0x00000002.
  - Signed → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
  - Unsigned → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **Unsigned maximum:** a=b=0xFFFFFFFF, `is_signed`=0 → `hi`=0xFFFFFFFE, `lo`=0x00000001. Also 0x80000000×0xFFFFFFFF signed → `hi`=0x00000000, `lo`=0x80000000.
- **Busy-period robustness:**
  - Start 7×6 signed.
  - Pulse `start` with a=0x1234, b=0x10 during RUN, and toggle `a`/`is_signed`.
  - Result must be `hi`=0, `lo`=0x2A with a single `done`. The prior `hi`/`lo` must be held throughout RUN.
- **Reset mid-operation:**
  - Assert `reset` at iteration 10 of 0x12345678×0x9ABCDEF0.
  - `hi`/`lo`/`busy`/`done` must go to 0 immediately, with no later `done`.
  - A following 3×−5 signed run yields `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- **Back-to-back and width:**
  - Hold `start`=1 for two operations; the second is accepted in the DONE cycle, giving `done` pulses exactly 34 cycles apart.
  - Rerun a random signed/unsigned sweep at WIDTH=8 against a reference product (e.g. 0x80×0x80 signed → `hi`=0x40, `lo`=0x00).
